// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and frame-length helper for the framed UART transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t ST_IDLE   = 3'd0;
    localparam tx_state_t ST_START  = 3'd1;
    localparam tx_state_t ST_DATA   = 3'd2;
    localparam tx_state_t ST_PARITY = 3'd3;
    localparam tx_state_t ST_STOP   = 3'd4;

    // Length of one frame in clock cycles; with clk_per_bit=1 it gives the bit-slot count.
    function automatic int frame_len(input int clk_per_bit, input int data_bits,
                                     input int parity_mode, input int stop_bits);
        return (1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits) * clk_per_bit;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter; bit_done marks the last cycle of each serial bit.
module uart_bit_timer
#(
    parameter int CLK_PER_BIT = 32
)
(
    input  logic MasterClk,
    input  logic MasterReset,
    input  logic restart,
    output logic bit_done
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge MasterClk) begin
        if (MasterReset || restart) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_done = (count == LAST);

endmodule

// File: rtl/uart_tx_framed.sv
// Parametrised UART transmitter with a one-entry holding buffer for gap-free back-to-back frames.
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 32,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
)
(
    input  logic                 MasterClk,
    input  logic                 MasterReset,
    input  logic                 tx_datavalid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] Byte_to_transmit,
    output logic                 tx_active,
    output logic                 Serial_Data,
    output logic                 tx_complete
);

    if (CLK_PER_BIT < 2 || CLK_PER_BIT > 65535) begin : g_bad_clk_per_bit
        $error("uart_tx_framed: CLK_PER_BIT must be 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_framed: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_ODD && PARITY_MODE != PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_framed: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_framed: STOP_BITS must be 1 or 2");
    end

    // Slot 0 is the start bit, slots 1..DATA_BITS carry data, then parity and stop slots.
    localparam int FRAME_BITS = frame_len(1, DATA_BITS, PARITY_MODE, STOP_BITS);
    localparam int SLOT_W     = $clog2(FRAME_BITS);
    localparam int IDX_W      = $clog2(DATA_BITS);
    localparam logic [SLOT_W-1:0] LAST_DATA_SLOT = SLOT_W'(DATA_BITS);
    localparam logic [SLOT_W-1:0] LAST_SLOT      = SLOT_W'(FRAME_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] hold_data;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_bit;
    logic [SLOT_W-1:0]    slot;
    logic [IDX_W-1:0]     data_idx;
    logic                 bit_done;
    logic                 restart;
    logic                 accept;
    logic                 last_stop;
    logic                 load;

    assign accept    = tx_datavalid && tx_ready;
    assign last_stop = (state == ST_STOP) && bit_done && (slot == LAST_SLOT);
    assign load      = !tx_ready && ((state == ST_IDLE) || last_stop);
    assign restart   = (state == ST_IDLE);
    assign data_idx  = slot[IDX_W-1:0];

    uart_bit_timer #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_bit_timer (
        .MasterClk   (MasterClk),
        .MasterReset (MasterReset),
        .restart     (restart),
        .bit_done    (bit_done)
    );

    // tx_ready doubles as the inverted holding-full flag.
    always_ff @(posedge MasterClk) begin
        if (MasterReset) begin
            tx_ready  <= 1'b1;
            hold_data <= '0;
        end else if (accept) begin
            hold_data <= Byte_to_transmit;
            tx_ready  <= 1'b0;
        end else if (load) begin
            tx_ready  <= 1'b1;
        end
    end

    always_ff @(posedge MasterClk) begin
        if (MasterReset) begin
            state       <= ST_IDLE;
            shift       <= '0;
            parity_bit  <= 1'b0;
            slot        <= '0;
            Serial_Data <= 1'b1;
            tx_active   <= 1'b0;
            tx_complete <= 1'b0;
        end else begin
            tx_complete <= last_stop;
            if (load) begin
                shift       <= hold_data;
                parity_bit  <= (PARITY_MODE == PARITY_ODD) ? ~^hold_data : ^hold_data;
                slot        <= '0;
                state       <= ST_START;
                Serial_Data <= 1'b0;
                tx_active   <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_START: begin
                        if (bit_done) begin
                            state       <= ST_DATA;
                            slot        <= SLOT_W'(1);
                            Serial_Data <= shift[0];
                        end
                    end
                    ST_DATA: begin
                        if (bit_done) begin
                            slot <= slot + 1'b1;
                            if (slot == LAST_DATA_SLOT) begin
                                if (PARITY_MODE != PARITY_NONE) begin
                                    state       <= ST_PARITY;
                                    Serial_Data <= parity_bit;
                                end else begin
                                    state       <= ST_STOP;
                                    Serial_Data <= 1'b1;
                                end
                            end else begin
                                // Data bit i lives in slot i+1, so the current slot number is the next index.
                                Serial_Data <= shift[data_idx];
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_done) begin
                            state       <= ST_STOP;
                            slot        <= slot + 1'b1;
                            Serial_Data <= 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (bit_done) begin
                            if (slot == LAST_SLOT) begin
                                state     <= ST_IDLE;
                                slot      <= '0;
                                tx_active <= 1'b0;
                            end else begin
                                slot <= slot + 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Self-checking bench: five differently configured transmitters against a queue-based line model.
module tb_uart_tx_framed;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       v   [5];
    logic [8:0] din [5];
    logic       ser [5];
    logic       act [5];
    logic       cmp [5];
    logic       rdy [5];

    int cfg_cpb [5] = '{4, 4, 4, 4, 2};
    int cfg_db  [5] = '{8, 8, 8, 7, 5};
    int cfg_pm  [5] = '{2, 1, 0, 0, 1};
    int cfg_sb  [5] = '{1, 1, 1, 2, 2};

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int act_cnt = 0;
    int cmp_cnt = 0;

    // Model of the instance currently in use: per-cycle line entries {serial, last-cycle-of-frame}.
    int       mk = 0;
    bit [1:0] q[$];
    bit       cur_last = 1'b0;
    bit       m_hold = 1'b0;
    bit [8:0] m_word = '0;
    bit       m_ser = 1'b1;
    bit       m_act = 1'b0;
    bit       m_cmp = 1'b0;
    bit       m_rdy = 1'b1;
    bit       m_acc = 1'b0;

    always #5 clk = ~clk;

    uart_tx_framed #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_dut0 (
        .MasterClk(clk), .MasterReset(rst), .tx_datavalid(v[0]), .tx_ready(rdy[0]),
        .Byte_to_transmit(din[0][7:0]), .tx_active(act[0]), .Serial_Data(ser[0]), .tx_complete(cmp[0]));
    uart_tx_framed #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_dut1 (
        .MasterClk(clk), .MasterReset(rst), .tx_datavalid(v[1]), .tx_ready(rdy[1]),
        .Byte_to_transmit(din[1][7:0]), .tx_active(act[1]), .Serial_Data(ser[1]), .tx_complete(cmp[1]));
    uart_tx_framed #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut2 (
        .MasterClk(clk), .MasterReset(rst), .tx_datavalid(v[2]), .tx_ready(rdy[2]),
        .Byte_to_transmit(din[2][7:0]), .tx_active(act[2]), .Serial_Data(ser[2]), .tx_complete(cmp[2]));
    uart_tx_framed #(.CLK_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_dut3 (
        .MasterClk(clk), .MasterReset(rst), .tx_datavalid(v[3]), .tx_ready(rdy[3]),
        .Byte_to_transmit(din[3][6:0]), .tx_active(act[3]), .Serial_Data(ser[3]), .tx_complete(cmp[3]));
    uart_tx_framed #(.CLK_PER_BIT(2), .DATA_BITS(5), .PARITY_MODE(1), .STOP_BITS(2)) u_dut4 (
        .MasterClk(clk), .MasterReset(rst), .tx_datavalid(v[4]), .tx_ready(rdy[4]),
        .Byte_to_transmit(din[4][4:0]), .tx_active(act[4]), .Serial_Data(ser[4]), .tx_complete(cmp[4]));

    function automatic bit [8:0] word_mask(int k);
        return 9'((1 << cfg_db[k]) - 1);
    endfunction

    task automatic check_bit(string tag, int j, logic got, logic want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("[TB] FAIL %s dut%0d cycle %0d: observed %b expected %b", tag, j, cycle, got, want);
        end
    endtask

    task automatic check_int(string tag, int j, int got, int want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("[TB] FAIL %s dut%0d: observed %0d expected %0d", tag, j, got, want);
        end
    endtask

    // Frame built from the line rules: start 0, data LSB first, optional parity, stop 1s.
    task automatic push_frame(bit [8:0] w);
        bit bits[$];
        int ones;
        ones = $countones(w & word_mask(mk));
        bits.push_back(1'b0);
        for (int i = 0; i < cfg_db[mk]; i++) bits.push_back(w[i]);
        if (cfg_pm[mk] == 1) bits.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
        if (cfg_pm[mk] == 2) bits.push_back((ones % 2 == 1) ? 1'b1 : 1'b0);
        for (int i = 0; i < cfg_sb[mk]; i++) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < cfg_cpb[mk]; c++) begin
                q.push_back({bits[b], (b == bits.size() - 1) && (c == cfg_cpb[mk] - 1)});
            end
        end
    endtask

    task automatic step();
        bit [1:0] e;
        @(posedge clk);
        cycle++;
        m_acc = 1'b0;
        if (rst) begin
            q.delete();
            cur_last = 1'b0;
            m_hold   = 1'b0;
            m_ser    = 1'b1;
            m_act    = 1'b0;
            m_cmp    = 1'b0;
            m_rdy    = 1'b1;
        end else begin
            m_acc = v[mk] && m_rdy;
            m_cmp = cur_last;
            if (q.size() == 0 && m_hold) begin
                push_frame(m_word);
                m_hold = 1'b0;
            end
            if (m_acc) begin
                m_hold = 1'b1;
                m_word = din[mk] & word_mask(mk);
            end
            if (q.size() > 0) begin
                e        = q.pop_front();
                m_ser    = e[1];
                cur_last = e[0];
                m_act    = 1'b1;
            end else begin
                m_ser    = 1'b1;
                cur_last = 1'b0;
                m_act    = 1'b0;
            end
            m_rdy = !m_hold;
        end
        #1;
        for (int j = 0; j < 5; j++) begin
            check_bit("serial",   j, ser[j], (j == mk) ? m_ser : 1'b1);
            check_bit("active",   j, act[j], (j == mk) ? m_act : 1'b0);
            check_bit("complete", j, cmp[j], (j == mk) ? m_cmp : 1'b0);
            check_bit("ready",    j, rdy[j], (j == mk) ? m_rdy : 1'b1);
        end
        if (act[mk] === 1'b1) act_cnt++;
        if (cmp[mk] === 1'b1) cmp_cnt++;
    endtask

    task automatic send(int k, bit [8:0] w);
        int n;
        n = 0;
        mk = k;
        v[k] = 1'b1;
        din[k] = w;
        do begin
            step();
            n++;
        end while (!m_acc && n < 400);
        v[k] = 1'b0;
        if (!m_acc) begin
            tests++;
            fails++;
            $error("[TB] FAIL send_timeout dut%0d: observed no accept expected accept", k);
        end
    endtask

    task automatic wait_idle(int k);
        int n;
        n = 0;
        while ((q.size() != 0 || m_hold || cur_last || m_cmp) && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) begin
            tests++;
            fails++;
            $error("[TB] FAIL idle_timeout dut%0d: observed busy expected idle", k);
        end
    endtask

    task automatic pulse_busy(int k, bit [8:0] w);
        if (!m_rdy) begin
            v[k] = 1'b1;
            din[k] = w;
            step();
            v[k] = 1'b0;
        end
    endtask

    initial begin
        int n;
        for (int j = 0; j < 5; j++) begin
            v[j] = 1'b0;
            din[j] = '0;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        $display("[TB] single even-parity frame");
        act_cnt = 0; cmp_cnt = 0;
        send(0, 9'h0A5);
        step();
        check_bit("start_latency", 0, ser[0], 1'b0);
        wait_idle(0);
        check_int("even_frame_len", 0, act_cnt, frame_len(4, 8, PARITY_EVEN, 1));
        check_int("even_complete_cnt", 0, cmp_cnt, 1);

        $display("[TB] odd parity and no parity");
        act_cnt = 0;
        send(1, 9'h0A5);
        wait_idle(1);
        check_int("odd_frame_len", 1, act_cnt, 44);
        act_cnt = 0;
        send(2, 9'h0A5);
        wait_idle(2);
        check_int("none_frame_len", 2, act_cnt, 40);

        $display("[TB] back-to-back frames");
        act_cnt = 0; cmp_cnt = 0;
        send(0, 9'h00F);
        send(0, 9'h0F0);
        wait_idle(0);
        check_int("b2b_active_len", 0, act_cnt, 88);
        check_int("b2b_complete_cnt", 0, cmp_cnt, 2);

        $display("[TB] 7 data bits, two stop bits");
        act_cnt = 0;
        send(3, 9'h055);
        wait_idle(3);
        check_int("stop2_frame_len", 3, act_cnt, 40);

        $display("[TB] valid while not ready is ignored");
        cmp_cnt = 0;
        send(0, 9'h03C);
        send(0, 9'h0C3);
        for (int i = 0; i < 3; i++) pulse_busy(0, 9'h0FF);
        wait_idle(0);
        check_int("busy_pulse_frames", 0, cmp_cnt, 2);

        $display("[TB] two-cycle bits");
        act_cnt = 0;
        send(4, 9'h015);
        send(4, 9'h00A);
        wait_idle(4);
        check_int("cpb2_active_len", 4, act_cnt, 2 * frame_len(2, 5, PARITY_ODD, 2));

        $display("[TB] reset in third data bit with buffer full");
        send(0, 9'h05A);
        send(0, 9'h0C3);
        n = 0;
        while (q.size() > 29 && n < 100) begin
            step();
            n++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_bit("reset_serial", 0, ser[0], 1'b1);
        check_bit("reset_ready", 0, rdy[0], 1'b1);
        act_cnt = 0; cmp_cnt = 0;
        repeat (150) step();
        check_int("reset_no_complete", 0, cmp_cnt, 0);
        check_int("reset_no_frame", 0, act_cnt, 0);

        $display("[TB] randomized frames");
        for (int it = 0; it < 40; it++) begin
            int k;
            int words;
            k = $urandom_range(0, 4);
            words = $urandom_range(1, 3);
            for (int w = 0; w < words; w++) begin
                send(k, 9'($urandom) & word_mask(k));
                if ($urandom_range(0, 3) == 0) pulse_busy(k, 9'($urandom));
                repeat ($urandom_range(0, cfg_cpb[k] * 12)) step();
            end
            wait_idle(k);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_framed.md
Name: uart_tx_framed

Overview:
Parametrised UART transmitter. Successor to the fixed 8N1 transmitter: configurable data width, parity and stop-bit count. Adds a one-entry holding buffer with a valid/ready handshake, so frames can be sent back-to-back with no idle gap. Sits between a byte source (FIFO or CPU register) and the Serial_Data pin.

Parameters:
CLK_PER_BIT, 32, MasterClk cycles per serial bit; legal range is 2 to 65535.
DATA_BITS, 8, data bits per frame; legal range is 5 to 9.
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
MasterClk  in  1  system clock; all logic on rising edge.
MasterReset  in  1  synchronous, active-high reset.
tx_datavalid  in  1  source offers Byte_to_transmit this cycle.
tx_ready  out  1  holding buffer empty; a byte is accepted on an edge where tx_datavalid and tx_ready are both 1.
Byte_to_transmit  in  DATA_BITS  data word, sent LSB first.
tx_active  out  1  high while a frame (start through last stop bit) is on the line.
Serial_Data  out  1  serial line; idles high.
tx_complete  out  1  one-cycle pulse after each frame's final stop bit.

Behaviour:
- Reset (MasterReset=1 at an edge):
  - Outputs become Serial_Data=1, tx_active=0, tx_complete=0, tx_ready=1.
  - Holding buffer is cleared, FSM goes to IDLE, bit counter and index are cleared.
  - Reset mid-frame aborts the frame; the line returns high on the next cycle and no tx_complete is issued.
- Handshake and holding buffer:
  - tx_ready is registered and equals the inverse of holding-full.
  - On an accept edge the word is latched into the holding buffer and tx_ready falls the next cycle.
  - The holding buffer empties on the edge where the FSM loads it into the shifter.
  - Accept and load cannot coincide because tx_ready=0 while the buffer is full.
- FSM states: IDLE, START, DATA, PARITY, STOP, all Serial_Data outputs registered.
  - IDLE: Serial_Data=1. If the holding buffer is full, load the shifter, compute parity and go to START.
  - START: Serial_Data=0 for CLK_PER_BIT cycles, then DATA.
  - DATA: Serial_Data=shift[index] for CLK_PER_BIT cycles per bit, index 0..DATA_BITS-1. After the last bit go to PARITY if PARITY_MODE≠0, else STOP.
  - PARITY: drive the parity bit for CLK_PER_BIT cycles. Odd mode makes the total ones in data+parity odd; even mode makes it even.
  - STOP: Serial_Data=1 for STOP_BITS×CLK_PER_BIT cycles.
  - On the final cycle of STOP: if the holding buffer is full, load it and go straight to START, so the next start bit follows immediately. Otherwise go to IDLE.
- Latency: accept at edge N puts the start bit on Serial_Data from edge N+1 when the FSM is IDLE.
- Bit length: every bit lasts exactly CLK_PER_BIT cycles.
- Frame length: (1+DATA_BITS+(PARITY_MODE≠0)+STOP_BITS)×CLK_PER_BIT cycles.
- tx_active: set on the edge entering START; cleared on the edge leaving STOP to IDLE. It stays high across back-to-back frames.
- tx_complete: high for exactly one cycle, on the cycle after each frame's final stop bit. This applies both in back-to-back mode and on return to IDLE.
- Bit counter: width $clog2(CLK_PER_BIT), wraps to 0 at CLK_PER_BIT-1. The shifter holds DATA_BITS bits. Parity is computed once at load as an XOR reduction.
- tx_datavalid while tx_ready=0 is ignored. The source must hold its data until accepted.
- Elaboration check: an illegal parameter value causes an elaboration error.

Decomposition:
- Shared package uart_pkg holds:
  - PARITY_NONE/ODD/EVEN constants;
  - FSM state typedef (IDLE, START, DATA, PARITY, STOP);
  - a frame-length function used by both RTL and bench.
- One sub-module, uart_bit_timer:
  - parameter CLK_PER_BIT;
  - inputs MasterClk, MasterReset, restart;
  - output bit_done, a one-cycle pulse on a bit's last cycle.
- The FSM, holding buffer and shifter stay in uart_tx_framed.

Test Plan:
1. CLK_PER_BIT=4, DATA_BITS=8, PARITY_MODE=2, STOP_BITS=1; send 0xA5 -> Serial_Data sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles. Start bit appears 1 cycle after accept; tx_complete pulses once, 44 cycles after the start bit begins.
2. Same stream with PARITY_MODE=1, 0xA5 -> parity bit 1; PARITY_MODE=0 -> frame is 40 cycles with no parity slot.
3. Back-to-back: offer 0x0F and 0xF0 with tx_datavalid held high -> second accepted while the first is on the line. The second start bit begins on the cycle after the first's last stop cycle. tx_active stays high throughout; two tx_complete pulses occur, 44 cycles apart.
4. STOP_BITS=2, DATA_BITS=7, PARITY_MODE=0; send 7'h55 -> stop high for 8 cycles, total frame 40 cycles. Bits above DATA_BITS are never driven.
5. Reset asserted in the 3rd data bit with the holding buffer full -> next cycle Serial_Data=1, tx_active=0, tx_ready=1, and no tx_complete. The buffered word is never transmitted.
6. tx_datavalid pulsed while tx_ready=0 -> byte not accepted, line stream unchanged. CLK_PER_BIT=2 corner: every bit lasts exactly 2 cycles.
